// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, port owner codes, width helpers.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_MB = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MB = 1'b1
    } arb_owner_t;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    localparam int unsigned STRB_W = strb_w(DATA_W);

    logic              pipe_flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              mb_req;
    logic              mb_we;
    logic [ADDR_W-1:0] mb_addr;
    logic [DATA_W-1:0] mb_wdata;
    logic [STRB_W-1:0] mb_wstrb;
    logic              mb_gnt;
    logic              mb_rvalid;
    logic [DATA_W-1:0] mb_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;

    modport slave (
        input  pipe_flush, if_req, if_addr, mb_req, mb_we, mb_addr, mb_wdata, mb_wstrb,
               mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, mb_gnt, mb_rvalid, mb_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, stall_if
    );

    modport master (
        output pipe_flush, if_req, if_addr, mb_req, mb_we, mb_addr, mb_wdata, mb_wstrb,
               mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, mb_gnt, mb_rvalid, mb_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, stall_if
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of cycles fetch has waited for the port; only built with ARB_STARVE_GUARD_EN.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic granted,
    output logic hit_c
);
    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (granted) begin
            cnt_q <= '0;
        end else if (waiting && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_c = (cnt_q >= CNT_W'(LIMIT));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stage; one transaction outstanding at a time.
// Define ARB_STARVE_GUARD_EN to let fetch win ties after STARVE_LIMIT waiting cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned STRB_W = strb_w(DATA_W);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    arb_state_t        state_q, state_d;
    logic              drop_q, drop_d;
    logic              window_c;
    logic              fetch_first_c;
    logic              mb_win_c;
    logic              if_win_c;
    arb_owner_t        owner_c;
    logic [ADDR_W-1:0] addr_c;
    logic [STRB_W-1:0] strb_c;

    // A new grant may issue when idle or in the cycle the current response returns.
    assign window_c = (state_q == ARB_IDLE) || bus.mem_rvalid;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .waiting (bus.if_req & ~if_win_c),
        .granted (if_win_c),
        .hit_c   (fetch_first_c)
    );
`else
    assign fetch_first_c = 1'b0;
`endif

    assign mb_win_c = ~rst & window_c & bus.mb_req & ~(bus.if_req & fetch_first_c);
    assign if_win_c = ~rst & window_c & bus.if_req & ~mb_win_c;
    assign owner_c  = mb_win_c ? OWN_MB : OWN_IF;

    always_comb begin
        addr_c = bus.if_addr;
        strb_c = '0;
        if (owner_c == OWN_MB) begin
            addr_c = bus.mb_addr;
            strb_c = bus.mb_wstrb;
        end
    end

    assign bus.if_gnt    = if_win_c;
    assign bus.mb_gnt    = mb_win_c;
    assign bus.stall_if  = bus.if_req & ~if_win_c;
    assign bus.mem_req   = mb_win_c | if_win_c;
    assign bus.mem_we    = mb_win_c & bus.mb_we;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = bus.mb_wdata;
    assign bus.mem_wstrb = strb_c;

    // Responses route by current owner; a flushed fetch response never reaches the pipeline.
    assign bus.mb_rvalid = ~rst & (state_q == ARB_BUSY_MB) & bus.mem_rvalid;
    assign bus.mb_rdata  = bus.mem_rdata;
    assign bus.if_rvalid = ~rst & (state_q == ARB_BUSY_IF) & bus.mem_rvalid
                           & ~drop_q & ~bus.pipe_flush;
    assign bus.if_rdata  = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        if (window_c) begin
            if (mb_win_c) begin
                state_d = ARB_BUSY_MB;
            end else if (if_win_c) begin
                state_d = ARB_BUSY_IF;
            end else begin
                state_d = ARB_IDLE;
            end
        end
        if (state_q == ARB_BUSY_IF) begin
            if (bus.mem_rvalid) begin
                drop_d = 1'b0;
            end else if (bus.pipe_flush) begin
                drop_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized request/latency stream.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int          STARVE_LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;

    // Model: who holds the port (0 none, 1 fetch, 2 data), pending flush drop, fetch wait count.
    int m_owner;
    bit m_drop;
    int m_starve;
    bit win, tie_if;
    bit e_if_gnt, e_mb_gnt, e_mem_req, e_if_rv, e_mb_rv, e_stall;
    int cnt_if_gnt, cnt_mb_gnt, cnt_if_rv, cnt_mb_rv, cnt_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the inputs driven this cycle.
    task automatic eval();
        #2;
        win       = (m_owner == 0) || bus.mem_rvalid;
        tie_if    = GUARD && (m_starve >= STARVE_LIMIT);
        e_mb_gnt  = !rst && win && bus.mb_req && !(bus.if_req && tie_if);
        e_if_gnt  = !rst && win && bus.if_req && !e_mb_gnt;
        e_mem_req = e_mb_gnt || e_if_gnt;
        e_mb_rv   = !rst && (m_owner == 2) && bus.mem_rvalid;
        e_if_rv   = !rst && (m_owner == 1) && bus.mem_rvalid && !m_drop && !bus.pipe_flush;
        e_stall   = bus.if_req && !e_if_gnt;
        chk("if_gnt", bus.if_gnt, e_if_gnt);
        chk("mb_gnt", bus.mb_gnt, e_mb_gnt);
        chk("mem_req", bus.mem_req, e_mem_req);
        chk("if_rvalid", bus.if_rvalid, e_if_rv);
        chk("mb_rvalid", bus.mb_rvalid, e_mb_rv);
        chk("stall_if", bus.stall_if, e_stall);
        if (e_mem_req) begin
            chk("mem_we", bus.mem_we, e_mb_gnt && bus.mb_we);
            chk("mem_addr", bus.mem_addr, e_mb_gnt ? bus.mb_addr : bus.if_addr);
            chk("mem_wstrb", bus.mem_wstrb, e_mb_gnt ? bus.mb_wstrb : 4'h0);
            if (e_mb_gnt && bus.mb_we) chk("mem_wdata", bus.mem_wdata, bus.mb_wdata);
        end
        if (e_if_rv) chk("if_rdata", bus.if_rdata, bus.mem_rdata);
        if (e_mb_rv) chk("mb_rdata", bus.mb_rdata, bus.mem_rdata);
        cnt_if_gnt += int'(e_if_gnt);
        cnt_mb_gnt += int'(e_mb_gnt);
        cnt_if_rv  += int'(bus.if_rvalid);
        cnt_mb_rv  += int'(bus.mb_rvalid);
        if (!rst && (m_owner == 1) && bus.mem_rvalid && (m_drop || bus.pipe_flush)) cnt_drop++;
    endtask

    // Advance the model across the clock edge, then wait for the next drive point.
    task automatic adv();
        if (rst) begin
            m_owner  = 0;
            m_drop   = 1'b0;
            m_starve = 0;
        end else begin
            if (m_owner == 1) begin
                if (bus.mem_rvalid) m_drop = 1'b0;
                else if (bus.pipe_flush) m_drop = 1'b1;
            end
            if (e_if_gnt) m_starve = 0;
            else if (bus.if_req && m_starve < 15) m_starve++;
            if (e_mb_gnt) m_owner = 2;
            else if (e_if_gnt) m_owner = 1;
            else if (win) m_owner = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.if_req     = 1'b0;
        bus.mb_req     = 1'b0;
        bus.pipe_flush = 1'b0;
        for (int i = 0; i < 8 && m_owner != 0; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            eval();
            adv();
        end
        bus.mem_rvalid = 1'b0;
        chk("drain_idle", 64'(m_owner), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        bit rvn;
        int resp_cd;
        bit if_pend, mb_pend;

        n_tests = 0; n_fail = 0;
        m_owner = 0; m_drop = 1'b0; m_starve = 0;
        cnt_if_gnt = 0; cnt_mb_gnt = 0; cnt_if_rv = 0; cnt_mb_rv = 0; cnt_drop = 0;
        rst = 1'b1;
        bus.pipe_flush = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mb_req = 1'b0; bus.mb_we = 1'b0; bus.mb_addr = '0; bus.mb_wdata = '0;
        bus.mb_wstrb = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);

        // Reset: requests present but nothing granted or valid.
        bus.if_req = 1'b1; bus.mb_req = 1'b1; bus.mem_rvalid = 1'b1;
        eval();
        chk("rst_if_gnt", bus.if_gnt, 1'b0);
        chk("rst_mb_gnt", bus.mb_gnt, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_rvalid", {bus.if_rvalid, bus.mb_rvalid}, 2'b00);
        adv();
        bus.if_req = 1'b0; bus.mb_req = 1'b0; bus.mem_rvalid = 1'b0;
        eval(); adv();
        rst = 1'b0;

        // 1: single fetch.
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        eval();
        chk("t1_if_gnt", bus.if_gnt, 1'b1);
        chk("t1_mem_req", bus.mem_req, 1'b1);
        chk("t1_mem_addr", bus.mem_addr, 32'h100);
        adv();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        eval();
        chk("t1_if_rvalid", bus.if_rvalid, 1'b1);
        chk("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        adv();
        bus.mem_rvalid = 1'b0;

        // 2: store beats fetch, fetch issues back-to-back on the ack.
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.mb_req = 1'b1; bus.mb_we = 1'b1; bus.mb_addr = 32'h2000;
        bus.mb_wdata = 32'h12345678; bus.mb_wstrb = 4'b0011;
        eval();
        chk("t2_mb_gnt", bus.mb_gnt, 1'b1);
        chk("t2_if_gnt", bus.if_gnt, 1'b0);
        chk("t2_stall", bus.stall_if, 1'b1);
        chk("t2_mem_we", bus.mem_we, 1'b1);
        chk("t2_mem_wstrb", bus.mem_wstrb, 4'h3);
        adv();
        bus.mb_req = 1'b0; bus.mb_we = 1'b0; bus.mb_wstrb = 4'h0;
        eval(); adv();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
        eval();
        chk("t2_mb_ack", bus.mb_rvalid, 1'b1);
        chk("t2_b2b_if_gnt", bus.if_gnt, 1'b1);
        adv();
        bus.if_req = 1'b0; bus.mem_rdata = 32'hCAFEF00D;
        eval();
        chk("t2_if_rdata", bus.if_rdata, 32'hCAFEF00D);
        adv();
        bus.mem_rvalid = 1'b0;

        // 3: continuous data traffic with single-cycle memory.
        bus.mb_req = 1'b1; bus.mb_we = 1'b0; bus.mb_addr = 32'h40;
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        first = -1; rvn = 1'b0;
        for (int c = 0; c < 12 && first < 0; c++) begin
            bus.mem_rvalid = rvn; bus.mem_rdata = $urandom;
            eval();
            if (bus.if_gnt) first = c;
            rvn = e_mem_req;
            adv();
        end
        chk("t3_first_if_gnt", 64'(first), GUARD ? 64'd4 : 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // 4: flush while fetch in flight swallows its response.
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        eval(); chk("t4_if_gnt", bus.if_gnt, 1'b1); adv();
        bus.if_req = 1'b0; bus.pipe_flush = 1'b1;
        eval(); adv();
        bus.pipe_flush = 1'b0;
        eval(); adv();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_AAAA;
        eval(); chk("t4_dropped", bus.if_rvalid, 1'b0); adv();
        bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h304;
        eval(); chk("t4_if_gnt2", bus.if_gnt, 1'b1); adv();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
        eval();
        chk("t4_rvalid2", bus.if_rvalid, 1'b1);
        chk("t4_rdata2", bus.if_rdata, 32'h5555_5555);
        adv();
        bus.mem_rvalid = 1'b0;

        // 5: reset while a load is outstanding; the late response is ignored.
        bus.mb_req = 1'b1; bus.mb_we = 1'b0; bus.mb_addr = 32'h80;
        eval(); chk("t5_mb_gnt", bus.mb_gnt, 1'b1); adv();
        bus.mb_req = 1'b0; rst = 1'b1;
        eval(); adv();
        rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
        eval();
        chk("t5_stale_rvalid", bus.mb_rvalid, 1'b0);
        adv();
        bus.mem_rvalid = 1'b0; bus.mb_req = 1'b1; bus.mb_addr = 32'h84;
        eval(); chk("t5_regrant", bus.mb_gnt, 1'b1); adv();
        bus.mb_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3333_4444;
        eval(); chk("t5_rvalid", bus.mb_rvalid, 1'b1); adv();
        bus.mem_rvalid = 1'b0;

        // 6: random requesters, random 1..3 cycle memory latency, random flushes.
        cnt_if_gnt = 0; cnt_mb_gnt = 0; cnt_if_rv = 0; cnt_mb_rv = 0; cnt_drop = 0;
        resp_cd = 0; if_pend = 1'b0; mb_pend = 1'b0;
        for (int c = 0; c < 3200; c++) begin
            if (c >= 3000 && !if_pend && !mb_pend && resp_cd == 0 && m_owner == 0) break;
            bus.mem_rvalid = (resp_cd == 1);
            bus.mem_rdata  = $urandom;
            if (c < 3000 && !if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (c < 3000 && !mb_pend && $urandom_range(0, 3) == 0) begin
                mb_pend = 1'b1;
                bus.mb_we    = 1'($urandom);
                bus.mb_addr  = $urandom;
                bus.mb_wdata = $urandom;
                bus.mb_wstrb = bus.mb_we ? 4'($urandom) : 4'h0;
            end
            bus.if_req     = if_pend;
            bus.mb_req     = mb_pend;
            bus.pipe_flush = ($urandom_range(0, 7) == 0);
            eval();
            if (resp_cd > 0) resp_cd--;
            if (e_mem_req) begin
                chk("single_outstanding", 64'(resp_cd), 64'd0);
                resp_cd = int'($urandom_range(1, 3));
            end
            if (e_if_gnt) if_pend = 1'b0;
            if (e_mb_gnt) mb_pend = 1'b0;
            adv();
        end
        bus.if_req = 1'b0; bus.mb_req = 1'b0; bus.pipe_flush = 1'b0; bus.mem_rvalid = 1'b0;
        chk("rand_drained", {if_pend, mb_pend, 1'(resp_cd != 0)}, 3'b000);
        chk("mb_resp_per_gnt", 64'(cnt_mb_rv), 64'(cnt_mb_gnt));
        chk("if_resp_per_gnt", 64'(cnt_if_rv + cnt_drop), 64'(cnt_if_gnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
